// File: rtl/game_state_ctrl.sv
// -----------------------------------------------------------------------------
// game_state_ctrl
//
// Frogger round/lives sequencer, placed directly after the collision detector.
// It samples the death and win collision flags while the game is in play and
// drives the level, the remaining lives, the freeze flag and the frog respawn
// pulse. Freeze delays are counted in video frames, using frame_tick.
//
// Optional feature macro: GAME_GODMODE_EN
//    defined   : death_collision is ignored in PLAY, so lives never decrement.
//                Wins still work normally.
//    undefined : full behaviour.
//
// Parameters
//    MAX_LEVEL      highest level; the level saturates here     (1..15)
//    START_LIVES    lives loaded when a game starts             (1..7)
//    FREEZE_FRAMES  frames held frozen after a death or win     (1..255)
//
// Ports
//    clk              in   system clock
//    rst_n            in   asynchronous, active-low reset
//    frame_tick       in   one-cycle pulse per video frame
//    start_btn        in   debounced start pulse
//    death_collision  in   frog overlaps an active car
//    win_collision    in   frog reached the top row
//    current_level    out  active level, 1..MAX_LEVEL
//    lives            out  remaining lives
//    freeze           out  high = frog and car motion disabled
//    frog_respawn     out  one-cycle pulse: reload the frog start position
//    level_up         out  one-cycle pulse on each level win
//    game_over        out  high while in GAME_OVER
//
// State table
//    state        | meaning
//    S_IDLE       | powered up; frozen, waiting for start_btn
//    S_PLAY       | normal play; collisions are sampled
//    S_DYING      | frozen after a death; freeze frames are being counted
//    S_WON        | frozen after a level win; freeze frames are being counted
//    S_GAME_OVER  | no lives left; frozen, waiting for start_btn
// -----------------------------------------------------------------------------
module game_state_ctrl #(
   parameter int unsigned MAX_LEVEL     = 8,
   parameter int unsigned START_LIVES   = 3,
   parameter int unsigned FREEZE_FRAMES = 30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       start_btn,
   input  logic       death_collision,
   input  logic       win_collision,
   output logic [3:0] current_level,
   output logic [2:0] lives,
   output logic       freeze,
   output logic       frog_respawn,
   output logic       level_up,
   output logic       game_over
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PLAY,
      S_DYING,
      S_WON,
      S_GAME_OVER
   } state_t;

   localparam logic [3:0] LVL_MAX    = 4'(MAX_LEVEL);
   localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);
   localparam logic [7:0] FRZ_LAST   = 8'(FREEZE_FRAMES);

   state_t     r_state;
   logic [7:0] r_frz_cnt;

   logic       w_death;
   logic [7:0] w_cnt_next;
   logic       w_expire;

`ifdef GAME_GODMODE_EN
   assign w_death = 1'b0;
`else
   assign w_death = death_collision;
`endif

   // The counter is cleared on entry, so a tick that coincides with the
   // entering edge is not counted. Expiry is the tick that takes the count
   // to FREEZE_FRAMES.
   assign w_cnt_next = r_frz_cnt + 8'd1;
   assign w_expire   = frame_tick && (w_cnt_next == FRZ_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_frz_cnt     <= 8'd0;
         current_level <= 4'd1;
         lives         <= LIVES_INIT;
         freeze        <= 1'b1;
         frog_respawn  <= 1'b0;
         level_up      <= 1'b0;
         game_over     <= 1'b0;
      end else begin
         frog_respawn <= 1'b0;
         level_up     <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (start_btn) begin
                  r_state       <= S_PLAY;
                  frog_respawn  <= 1'b1;
                  freeze        <= 1'b0;
                  lives         <= LIVES_INIT;
                  current_level <= 4'd1;
               end
            end

            S_PLAY: begin
               // A death wins over a simultaneous win.
               if (w_death) begin
                  r_state   <= S_DYING;
                  lives     <= lives - 3'd1;
                  freeze    <= 1'b1;
                  r_frz_cnt <= 8'd0;
               end else if (win_collision) begin
                  r_state   <= S_WON;
                  freeze    <= 1'b1;
                  r_frz_cnt <= 8'd0;
                  level_up  <= 1'b1;
               end
            end

            S_DYING: begin
               if (frame_tick) begin
                  r_frz_cnt <= w_cnt_next;
               end
               if (w_expire) begin
                  if (lives == 3'd0) begin
                     r_state   <= S_GAME_OVER;
                     game_over <= 1'b1;
                  end else begin
                     r_state      <= S_PLAY;
                     frog_respawn <= 1'b1;
                     freeze       <= 1'b0;
                  end
               end
            end

            S_WON: begin
               if (frame_tick) begin
                  r_frz_cnt <= w_cnt_next;
               end
               if (w_expire) begin
                  r_state      <= S_PLAY;
                  frog_respawn <= 1'b1;
                  freeze       <= 1'b0;
                  // The new level is driven on the same edge as the respawn,
                  // so the collision detector sees both together.
                  if (current_level >= LVL_MAX) begin
                     current_level <= LVL_MAX;
                  end else begin
                     current_level <= current_level + 4'd1;
                  end
               end
            end

            S_GAME_OVER: begin
               if (start_btn) begin
                  r_state       <= S_PLAY;
                  lives         <= LIVES_INIT;
                  current_level <= 4'd1;
                  frog_respawn  <= 1'b1;
                  game_over     <= 1'b0;
                  freeze        <= 1'b0;
               end
            end

            default: begin
               r_state <= S_IDLE;
               freeze  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       frame_tick = 1'b0;
   logic       start_btn = 1'b0;
   logic       death_collision = 1'b0;
   logic       win_collision = 1'b0;
   logic [3:0] current_level;
   logic [2:0] lives;
   logic       freeze;
   logic       frog_respawn;
   logic       level_up;
   logic       game_over;

   int nchecks = 0;
   int nerrors = 0;

   always #5 clk = ~clk;

   game_state_ctrl #(
      .MAX_LEVEL     (8),
      .START_LIVES   (3),
      .FREEZE_FRAMES (30)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .frame_tick      (frame_tick),
      .start_btn       (start_btn),
      .death_collision (death_collision),
      .win_collision   (win_collision),
      .current_level   (current_level),
      .lives           (lives),
      .freeze          (freeze),
      .frog_respawn    (frog_respawn),
      .level_up        (level_up),
      .game_over       (game_over)
   );

   // Stimulus helper: n frame ticks, each one cycle high then one cycle low.
   // Counts how many samples show frog_respawn high.
   task automatic tick_n(input int n, output int resp);
      resp = 0;
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         @(negedge clk);
         frame_tick = 1'b0;
         resp += int'(frog_respawn);
         @(negedge clk);
         resp += int'(frog_respawn);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      nchecks++; if (current_level !== 4'd1) begin nerrors++; $display("FAIL reset_level: got %0d expected 1", current_level); end
      nchecks++; if (lives !== 3'd3) begin nerrors++; $display("FAIL reset_lives: got %0d expected 3", lives); end
      nchecks++; if (freeze !== 1'b1) begin nerrors++; $display("FAIL reset_freeze: got %0b expected 1", freeze); end
      nchecks++; if (frog_respawn !== 1'b0) begin nerrors++; $display("FAIL reset_respawn: got %0b expected 0", frog_respawn); end
      nchecks++; if (level_up !== 1'b0) begin nerrors++; $display("FAIL reset_level_up: got %0b expected 0", level_up); end
      nchecks++; if (game_over !== 1'b0) begin nerrors++; $display("FAIL reset_game_over: got %0b expected 0", game_over); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      death_collision = 1'b1;
      @(negedge clk);
      death_collision = 1'b0;
      nchecks++; if (lives !== 3'd3) begin nerrors++; $display("FAIL idle_ignores_death: lives got %0d expected 3", lives); end
      nchecks++; if (freeze !== 1'b1 || frog_respawn !== 1'b0) begin nerrors++; $display("FAIL idle_hold: freeze/respawn got %0b/%0b expected 1/0", freeze, frog_respawn); end
   endtask

   task automatic test_start();
      start_btn = 1'b1;
      @(negedge clk);
      start_btn = 1'b0;
      nchecks++; if (frog_respawn !== 1'b1) begin nerrors++; $display("FAIL start_respawn: got %0b expected 1", frog_respawn); end
      nchecks++; if (freeze !== 1'b0) begin nerrors++; $display("FAIL start_freeze: got %0b expected 0", freeze); end
      nchecks++; if (lives !== 3'd3) begin nerrors++; $display("FAIL start_lives: got %0d expected 3", lives); end
      nchecks++; if (current_level !== 4'd1) begin nerrors++; $display("FAIL start_level: got %0d expected 1", current_level); end
      @(negedge clk);
      nchecks++; if (frog_respawn !== 1'b0) begin nerrors++; $display("FAIL start_respawn_width: got %0b expected 0", frog_respawn); end
      nchecks++; if (freeze !== 1'b0) begin nerrors++; $display("FAIL start_play_freeze: got %0b expected 0", freeze); end
   endtask

   task automatic test_death_hold();
      int r;
      death_collision = 1'b1;
      @(negedge clk);
      nchecks++; if (lives !== 3'd2) begin nerrors++; $display("FAIL death_lives: got %0d expected 2", lives); end
      nchecks++; if (freeze !== 1'b1) begin nerrors++; $display("FAIL death_freeze: got %0b expected 1", freeze); end
      repeat (49) @(negedge clk);
      death_collision = 1'b0;
      nchecks++; if (lives !== 3'd2) begin nerrors++; $display("FAIL death_held_once: lives got %0d expected 2", lives); end
      start_btn = 1'b1;
      @(negedge clk);
      start_btn = 1'b0;
      nchecks++; if (lives !== 3'd2 || frog_respawn !== 1'b0) begin nerrors++; $display("FAIL dying_ignores_start: lives/respawn got %0d/%0b expected 2/0", lives, frog_respawn); end
      tick_n(29, r);
      nchecks++; if (r !== 0) begin nerrors++; $display("FAIL death_early_respawn: got %0d expected 0", r); end
      nchecks++; if (freeze !== 1'b1) begin nerrors++; $display("FAIL death_freeze_29: got %0b expected 1", freeze); end
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      nchecks++; if (frog_respawn !== 1'b1) begin nerrors++; $display("FAIL death_expire_respawn: got %0b expected 1", frog_respawn); end
      nchecks++; if (freeze !== 1'b0) begin nerrors++; $display("FAIL death_expire_freeze: got %0b expected 0", freeze); end
      nchecks++; if (lives !== 3'd2) begin nerrors++; $display("FAIL death_expire_lives: got %0d expected 2", lives); end
      @(negedge clk);
      nchecks++; if (frog_respawn !== 1'b0) begin nerrors++; $display("FAIL death_respawn_width: got %0b expected 0", frog_respawn); end
   endtask

   task automatic test_game_over();
      int r;
      // Tick coincident with the entering edge must not be counted.
      death_collision = 1'b1;
      frame_tick = 1'b1;
      @(negedge clk);
      death_collision = 1'b0;
      frame_tick = 1'b0;
      nchecks++; if (lives !== 3'd1) begin nerrors++; $display("FAIL go_death2_lives: got %0d expected 1", lives); end
      tick_n(29, r);
      nchecks++; if (freeze !== 1'b1 || r !== 0) begin nerrors++; $display("FAIL entry_tick_counted: freeze/respawns got %0b/%0d expected 1/0", freeze, r); end
      tick_n(1, r);
      nchecks++; if (r !== 1 || freeze !== 1'b0) begin nerrors++; $display("FAIL go_death2_expire: respawns/freeze got %0d/%0b expected 1/0", r, freeze); end
      death_collision = 1'b1;
      @(negedge clk);
      death_collision = 1'b0;
      nchecks++; if (lives !== 3'd0) begin nerrors++; $display("FAIL go_death3_lives: got %0d expected 0", lives); end
      tick_n(29, r);
      nchecks++; if (r !== 0 || game_over !== 1'b0) begin nerrors++; $display("FAIL go_early: respawns/game_over got %0d/%0b expected 0/0", r, game_over); end
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      nchecks++; if (game_over !== 1'b1) begin nerrors++; $display("FAIL go_flag: got %0b expected 1", game_over); end
      nchecks++; if (frog_respawn !== 1'b0) begin nerrors++; $display("FAIL go_no_respawn: got %0b expected 0", frog_respawn); end
      nchecks++; if (freeze !== 1'b1) begin nerrors++; $display("FAIL go_freeze: got %0b expected 1", freeze); end
      death_collision = 1'b1;
      win_collision = 1'b1;
      @(negedge clk);
      death_collision = 1'b0;
      win_collision = 1'b0;
      @(negedge clk);
      nchecks++; if (lives !== 3'd0 || level_up !== 1'b0 || game_over !== 1'b1) begin nerrors++; $display("FAIL go_ignores_collisions: lives/level_up/game_over got %0d/%0b/%0b expected 0/0/1", lives, level_up, game_over); end
      start_btn = 1'b1;
      @(negedge clk);
      start_btn = 1'b0;
      nchecks++; if (lives !== 3'd3 || current_level !== 4'd1) begin nerrors++; $display("FAIL restart_lives_level: got %0d/%0d expected 3/1", lives, current_level); end
      nchecks++; if (frog_respawn !== 1'b1 || game_over !== 1'b0 || freeze !== 1'b0) begin nerrors++; $display("FAIL restart_flags: respawn/game_over/freeze got %0b/%0b/%0b expected 1/0/0", frog_respawn, game_over, freeze); end
      @(negedge clk);
   endtask

   task automatic test_both();
      int r;
      death_collision = 1'b1;
      win_collision = 1'b1;
      @(negedge clk);
      death_collision = 1'b0;
      win_collision = 1'b0;
      nchecks++; if (lives !== 3'd2) begin nerrors++; $display("FAIL both_lives: got %0d expected 2", lives); end
      nchecks++; if (level_up !== 1'b0) begin nerrors++; $display("FAIL both_level_up: got %0b expected 0", level_up); end
      nchecks++; if (freeze !== 1'b1) begin nerrors++; $display("FAIL both_freeze: got %0b expected 1", freeze); end
      tick_n(30, r);
      nchecks++; if (r !== 1 || current_level !== 4'd1 || freeze !== 1'b0) begin nerrors++; $display("FAIL both_expire: respawns/level/freeze got %0d/%0d/%0b expected 1/1/0", r, current_level, freeze); end
   endtask

   task automatic test_wins();
      int r;
      int ups;
      int exp_lvl;
      ups = 0;
      exp_lvl = 1;
      for (int k = 1; k <= 9; k++) begin
         // Win held two cycles: the second must be ignored in WON.
         win_collision = 1'b1;
         @(negedge clk);
         ups += int'(level_up);
         nchecks++; if (level_up !== 1'b1 || freeze !== 1'b1) begin nerrors++; $display("FAIL win%0d_entry: level_up/freeze got %0b/%0b expected 1/1", k, level_up, freeze); end
         nchecks++; if (current_level !== 4'(exp_lvl)) begin nerrors++; $display("FAIL win%0d_level_early: got %0d expected %0d", k, current_level, exp_lvl); end
         @(negedge clk);
         win_collision = 1'b0;
         ups += int'(level_up);
         tick_n(29, r);
         nchecks++; if (r !== 0 || current_level !== 4'(exp_lvl)) begin nerrors++; $display("FAIL win%0d_hold: respawns/level got %0d/%0d expected 0/%0d", k, r, current_level, exp_lvl); end
         frame_tick = 1'b1;
         @(negedge clk);
         frame_tick = 1'b0;
         exp_lvl = (exp_lvl < 8) ? exp_lvl + 1 : 8;
         nchecks++; if (frog_respawn !== 1'b1 || level_up !== 1'b0) begin nerrors++; $display("FAIL win%0d_expire: respawn/level_up got %0b/%0b expected 1/0", k, frog_respawn, level_up); end
         nchecks++; if (current_level !== 4'(exp_lvl)) begin nerrors++; $display("FAIL win%0d_level: got %0d expected %0d", k, current_level, exp_lvl); end
         @(negedge clk);
      end
      nchecks++; if (ups !== 9) begin nerrors++; $display("FAIL win_level_up_count: got %0d expected 9", ups); end
      nchecks++; if (lives !== 3'd2) begin nerrors++; $display("FAIL win_lives: got %0d expected 2", lives); end
   endtask

   task automatic test_reset_mid();
      int r;
      death_collision = 1'b1;
      @(negedge clk);
      death_collision = 1'b0;
      nchecks++; if (lives !== 3'd1) begin nerrors++; $display("FAIL rm_death_lives: got %0d expected 1", lives); end
      tick_n(10, r);
      #2 rst_n = 1'b0;
      #1;
      nchecks++; if (current_level !== 4'd1 || lives !== 3'd3) begin nerrors++; $display("FAIL rm_level_lives: got %0d/%0d expected 1/3", current_level, lives); end
      nchecks++; if (freeze !== 1'b1 || frog_respawn !== 1'b0 || level_up !== 1'b0 || game_over !== 1'b0) begin nerrors++; $display("FAIL rm_flags: freeze/respawn/level_up/game_over got %0b/%0b/%0b/%0b expected 1/0/0/0", freeze, frog_respawn, level_up, game_over); end
      @(negedge clk);
      rst_n = 1'b1;
      tick_n(25, r);
      nchecks++; if (r !== 0 || freeze !== 1'b1) begin nerrors++; $display("FAIL rm_idle_after: respawns/freeze got %0d/%0b expected 0/1", r, freeze); end
      start_btn = 1'b1;
      @(negedge clk);
      start_btn = 1'b0;
      nchecks++; if (frog_respawn !== 1'b1 || freeze !== 1'b0) begin nerrors++; $display("FAIL rm_restart: respawn/freeze got %0b/%0b expected 1/0", frog_respawn, freeze); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_start();
      test_death_hold();
      test_game_over();
      test_both();
      test_wins();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
